// File: rtl/logic_cfg_sequencer.sv
// Shares the programmable-logic write port between CPU passthrough and a preset ROM loader (40 writes per preset).
// CFG_SEQ_TIMEOUT_EN adds a pl_ready watchdog that aborts a load and raises a sticky error.
module logic_cfg_sequencer #(
    parameter int NUM_GATES      = 8,
    parameter int REGS_PER_GATE  = 5,
    parameter int PRESET_W       = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_valid,
    input  logic [15:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic [3:0]            cpu_wstrb,
    output logic                  cpu_ready,
    output logic [31:0]           cpu_rdata,
    input  logic                  load_start,
    input  logic [PRESET_W-1:0]   preset_sel,
    output logic [PRESET_W+5:0]   rom_addr,
    input  logic [7:0]            rom_data,
    output logic                  pl_valid,
    output logic [15:0]           pl_addr,
    output logic [31:0]           pl_wdata,
    output logic [3:0]            pl_wstrb,
    input  logic                  pl_ready,
    input  logic [31:0]           pl_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_ACK, S_DONE
    } state_t;

    state_t              state;
    logic [2:0]          gate;
    logic [2:0]          regn;
    logic [PRESET_W-1:0] preset;
    logic                pending;
    logic [7:0]          rom_q;
    logic                ld_valid;
    logic [15:0]         ld_addr;
    logic [31:0]         ld_wdata;
    logic [3:0]          ld_wstrb;
    logic [5:0]          entry;
    logic                cpu_owner;
    logic                grant;
    logic                last_reg;
    logic                last_gate;
`ifdef CFG_SEQ_TIMEOUT_EN
    logic [7:0]          tmo_cnt;
    logic                error_q;
`endif

    assign entry     = {1'b0, gate, 2'b00} + {3'b000, gate} + {3'b000, regn};
    assign rom_addr  = {preset, entry};
    assign last_reg  = (regn == 3'(REGS_PER_GATE - 1));
    assign last_gate = (gate == 3'(NUM_GATES - 1));
    assign cpu_owner = (state == S_IDLE);

    // Ownership may only move once the CPU has no transaction outstanding.
    assign grant = cpu_owner && (load_start || pending) && (!cpu_valid || pl_ready);

    assign pl_valid  = cpu_owner ? cpu_valid : ld_valid;
    assign pl_addr   = cpu_owner ? cpu_addr  : ld_addr;
    assign pl_wdata  = cpu_owner ? cpu_wdata : ld_wdata;
    assign pl_wstrb  = cpu_owner ? cpu_wstrb : ld_wstrb;
    assign cpu_ready = cpu_owner && cpu_valid && pl_ready;
    assign cpu_rdata = pl_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            gate     <= '0;
            regn     <= '0;
            preset   <= '0;
            pending  <= 1'b0;
            rom_q    <= '0;
            ld_valid <= 1'b0;
            ld_addr  <= '0;
            ld_wdata <= '0;
            ld_wstrb <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef CFG_SEQ_TIMEOUT_EN
            tmo_cnt  <= '0;
            error_q  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        preset <= preset_sel;
`ifdef CFG_SEQ_TIMEOUT_EN
                        error_q <= 1'b0;
`endif
                    end
                    if (grant) begin
                        state   <= S_FETCH;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                    end else if (load_start) begin
                        pending <= 1'b1;
                    end
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    rom_q <= rom_data;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    ld_addr  <= {5'b0, gate, 5'b0, regn};
                    ld_wdata <= {24'b0, rom_q};
                    ld_wstrb <= 4'b0001;
                    ld_valid <= 1'b1;
                    state    <= S_ACK;
`ifdef CFG_SEQ_TIMEOUT_EN
                    tmo_cnt  <= '0;
`endif
                end
                S_ACK: begin
                    if (pl_ready) begin
                        ld_valid <= 1'b0;
                        if (last_reg) begin
                            regn <= '0;
                            if (last_gate) begin
                                gate  <= '0;
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                gate  <= gate + 3'd1;
                                state <= S_FETCH;
                            end
                        end else begin
                            regn  <= regn + 3'd1;
                            state <= S_FETCH;
                        end
                    end
`ifdef CFG_SEQ_TIMEOUT_EN
                    else if (tmo_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        ld_valid <= 1'b0;
                        error_q  <= 1'b1;
                        busy     <= 1'b0;
                        gate     <= '0;
                        regn     <= '0;
                        state    <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CFG_SEQ_TIMEOUT_EN
    assign error = error_q;
`else
    assign error = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif
endmodule

// File: tb/tb_logic_cfg_sequencer.sv
// Scoreboard bench for logic_cfg_sequencer: expected pl writes are queued at issue, a negedge monitor pops them on each handshake.
module tb_logic_cfg_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        load_start;
    logic [1:0]  preset_sel;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        pl_valid;
    logic [15:0] pl_addr;
    logic [31:0] pl_wdata;
    logic [3:0]  pl_wstrb;
    logic        pl_ready = 1'b0;
    logic [31:0] pl_rdata;
    logic        busy;
    logic        done;
    logic        error;

    logic        stuck;
    logic [7:0]  rom [0:255];
    logic [51:0] exp_q [$];
    logic [51:0] mon_e;
    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int cpu_rdy_cnt = 0;
    int done_cnt = 0;

    logic_cfg_sequencer dut (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .load_start(load_start), .preset_sel(preset_sel),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pl_valid(pl_valid), .pl_addr(pl_addr), .pl_wdata(pl_wdata), .pl_wstrb(pl_wstrb),
        .pl_ready(pl_ready), .pl_rdata(pl_rdata),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    assign pl_rdata = 32'hCAFE_F00D;

    always @(posedge clk) rom_data <= rom[rom_addr];

    // Slave acks one cycle after it first sees pl_valid, as a single-cycle pulse.
    always @(posedge clk or posedge reset) begin
        if (reset) pl_ready <= 1'b0;
        else       pl_ready <= pl_valid && !pl_ready && !stuck;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (pl_valid && pl_ready) begin
                wr_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pl_write unexpected: addr=%h data=%h strb=%h, none expected", pl_addr, pl_wdata, pl_wstrb);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({pl_addr, pl_wdata, pl_wstrb} !== mon_e) begin
                        bad++;
                        $display("FAIL pl_write #%0d: addr=%h data=%h strb=%h, want addr=%h data=%h strb=%h",
                                 wr_cnt, pl_addr, pl_wdata, pl_wstrb, mon_e[51:36], mon_e[35:4], mon_e[3:0]);
                    end
                end
            end
            if (cpu_ready) cpu_rdy_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Preset 1 holds k at entry k, preset 2 holds 0x80+k.
    task automatic push_load(input int p);
        for (int k = 0; k < 40; k++) begin
            logic [15:0] a;
            logic [7:0]  d;
            a = 16'(((k / 5) << 8) | (k % 5));
            d = (p == 1) ? 8'(k) : 8'(8'h80 + k);
            exp_q.push_back({a, 24'h0, d, 4'b0001});
        end
    endtask

    task automatic start_load(input logic [1:0] p);
        @(negedge clk);
        preset_sel = p;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        preset_sel = ~p;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [31:0] d, input int budget);
        int n;
        @(negedge clk);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wstrb = 4'hF;
        cpu_valid = 1'b1;
        n = 0;
        while (!cpu_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("cpu_write_completes", cpu_ready, 1);
        if (cpu_ready) check("cpu_ready_not_busy", busy, 0);
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        cpu_wstrb = 4'h0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
    endtask

    initial begin
        int n;
        int base;
        int r0;
        int d0;
        reset = 1'b1;
        stuck = 1'b0;
        cpu_valid = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        cpu_wstrb = '0;
        load_start = 1'b0;
        preset_sel = '0;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
        for (int k = 0; k < 40; k++) begin
            rom[64 + k]  = 8'(k);
            rom[128 + k] = 8'(8'h80 + k);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("reset_pl_valid", pl_valid, 0);
        check("reset_cpu_ready", cpu_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);

        exp_q.push_back({16'h0104, 32'd3, 4'hF});
        r0 = cpu_rdy_cnt;
        cpu_write(16'h0104, 32'd3, 20);
        @(negedge clk);
        check("cpu_ready_pulses_once", cpu_rdy_cnt - r0, 1);
        check("rdata_passthrough", cpu_rdata, 32'hCAFE_F00D);

        push_load(1);
        d0 = done_cnt;
        start_load(1);
        check("busy_after_start", busy, 1);
        wait_done(400, n);
        check("load_cycles", n, 200);
        check("busy_in_done", busy, 1);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("done_pulses", done_cnt - d0, 1);
        check("load1_queue_empty", exp_q.size(), 0);

        exp_q.push_back({16'h0210, 32'h55, 4'hF});
        push_load(2);
        fork
            cpu_write(16'h0210, 32'h55, 50);
            start_load(2);
        join
        check("pending_load_started", busy, 1);
        wait_done(400, n);
        @(negedge clk);
        check("collide_queue_empty", exp_q.size(), 0);

        push_load(1);
        base = wr_cnt;
        start_load(1);
        n = 0;
        while (wr_cnt - base < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_entry10", wr_cnt - base, 10);
        exp_q.push_back({16'h0304, 32'h1234_5678, 4'hF});
        r0 = cpu_rdy_cnt;
        d0 = done_cnt;
        cpu_write(16'h0304, 32'h1234_5678, 400);
        check("cpu_after_done", done_cnt - d0, 1);
        @(negedge clk);
        check("held_cpu_ready_once", cpu_rdy_cnt - r0, 1);
        check("held_queue_empty", exp_q.size(), 0);

        push_load(1);
        base = wr_cnt;
        start_load(1);
        n = 0;
        while (!(wr_cnt - base >= 20 && pl_valid && !pl_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("entry20_pl_valid", pl_valid, 1);
        check("entry20_addr", pl_addr, 16'h0400);
        #2 reset = 1'b1;
        #1;
        check("reset_drops_pl_valid", pl_valid, 0);
        check("reset_drops_busy", busy, 0);
        exp_q.delete();
        base = wr_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check("no_writes_after_reset", wr_cnt - base, 0);
        check("idle_after_reset", busy, 0);
        push_load(1);
        start_load(1);
        wait_done(400, n);
        check("restart_cycles", n, 200);
        @(negedge clk);
        check("restart_queue_empty", exp_q.size(), 0);

`ifdef CFG_SEQ_TIMEOUT_EN
        stuck = 1'b1;
        d0 = done_cnt;
        start_load(2);
        n = 0;
        while (!pl_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (pl_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("timeout_valid_cycles", n, 255);
        check("timeout_error", error, 1);
        check("timeout_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("timeout_no_done", done_cnt - d0, 0);
        check("error_sticky", error, 1);
        stuck = 1'b0;
        push_load(2);
        start_load(2);
        check("error_cleared", error, 0);
        wait_done(400, n);
        @(negedge clk);
        check("post_timeout_queue_empty", exp_q.size(), 0);
`else
        check("error_tied_low", error, 0);
`endif

        repeat (10) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
